// File: rtl/n64_pi_address_latch.sv
// ---------------------------------------------------------------------------
// n64_pi_address_latch
//
// Front end of the N64 PI bus slave. The raw ALE_H / ALE_L / READ / WRITE
// pins and the multiplexed AD bus are passed through SYNC_STAGES-deep
// synchronisers. The 32-bit byte address is assembled from two AD phases,
// auto-incremented across a burst, and read/write requests are held for the
// downstream bank decoder / arbiter until acknowledged.
//
// Optional feature macro: N64_PI_READ_PREFETCH_EN
//   When defined, a read request is raised on entry to DATA and again after
//   every /READ rising edge (for the next address), so read data can be
//   fetched before the N64 drops /READ. A /READ falling edge then raises
//   nothing.
//
// Ports:
//   i_clk            system clock (only clock)
//   i_reset_n        asynchronous active-low reset
//   i_n64_aleh       raw ALE_H pin (async)
//   i_n64_alel       raw ALE_L pin (async)
//   i_n64_read_n     raw /READ pin (async, active-low)
//   i_n64_write_n    raw /WRITE pin (async, active-low)
//   i_n64_ad[15:0]   raw AD bus, synchronised alongside the strobes
//   o_address[31:0]  current PI byte address (bit 0 always 0)
//   o_address_valid  high while the FSM is in DATA
//   o_read_request   read request, held until i_ack
//   o_write_request  write request, held until i_ack
//   o_write_data     AD value captured at the /WRITE rising edge
//   i_ack            downstream accepts the pending request
//   o_overrun        sticky: a request event arrived while one was pending
// ---------------------------------------------------------------------------
module n64_pi_address_latch #(
    parameter int          SYNC_STAGES  = 2,
    parameter logic [31:0] ADDRESS_STEP = 32'd2
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_n64_aleh,
    input  logic        i_n64_alel,
    input  logic        i_n64_read_n,
    input  logic        i_n64_write_n,
    input  logic [15:0] i_n64_ad,
    output logic [31:0] o_address,
    output logic        o_address_valid,
    output logic        o_read_request,
    output logic        o_write_request,
    output logic [15:0] o_write_data,
    input  logic        i_ack,
    output logic        o_overrun
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ADDR_H = 2'd1,
        ST_ADDR_L = 2'd2,
        ST_DATA   = 2'd3
    } state_t;

    // Next burst address; 32-bit modulo and always half-word aligned.
    function automatic logic [31:0] next_address(input logic [31:0] addr);
        return (addr + ADDRESS_STEP) & 32'hFFFF_FFFE;
    endfunction

    // ------------------------------------------------------------------
    // Synchronisers and edge-detect delay flops
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] aleh_sync_r;
    logic [SYNC_STAGES-1:0] alel_sync_r;
    logic [SYNC_STAGES-1:0] read_n_sync_r;
    logic [SYNC_STAGES-1:0] write_n_sync_r;
    logic [15:0]            ad_sync_r [SYNC_STAGES];

    logic aleh_d_r;
    logic alel_d_r;
    logic read_n_d_r;
    logic write_n_d_r;

    logic        aleh_s;
    logic        alel_s;
    logic        read_n_s;
    logic        write_n_s;
    logic [15:0] ad_s;

    logic aleh_rise_s;
    logic aleh_fall_s;
    logic alel_fall_s;
    logic read_fall_s;
    logic read_rise_s;
    logic read_edge_s;
    logic write_rise_s;

    // Pin synchroniser chains; strobes idle low (ALE) or high (/READ, /WRITE).
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            aleh_sync_r    <= {SYNC_STAGES{1'b0}};
            alel_sync_r    <= {SYNC_STAGES{1'b0}};
            read_n_sync_r  <= {SYNC_STAGES{1'b1}};
            write_n_sync_r <= {SYNC_STAGES{1'b1}};
            for (int i = 0; i < SYNC_STAGES; i++) begin
                ad_sync_r[i] <= 16'h0000;
            end
        end else begin
            aleh_sync_r    <= {aleh_sync_r[SYNC_STAGES-2:0], i_n64_aleh};
            alel_sync_r    <= {alel_sync_r[SYNC_STAGES-2:0], i_n64_alel};
            read_n_sync_r  <= {read_n_sync_r[SYNC_STAGES-2:0], i_n64_read_n};
            write_n_sync_r <= {write_n_sync_r[SYNC_STAGES-2:0], i_n64_write_n};
            ad_sync_r[0]   <= i_n64_ad;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                ad_sync_r[i] <= ad_sync_r[i-1];
            end
        end
    end

    assign aleh_s    = aleh_sync_r[SYNC_STAGES-1];
    assign alel_s    = alel_sync_r[SYNC_STAGES-1];
    assign read_n_s  = read_n_sync_r[SYNC_STAGES-1];
    assign write_n_s = write_n_sync_r[SYNC_STAGES-1];
    assign ad_s      = ad_sync_r[SYNC_STAGES-1];

    // One-cycle delayed copies of the synchronised strobes for edge detection.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            aleh_d_r    <= 1'b0;
            alel_d_r    <= 1'b0;
            read_n_d_r  <= 1'b1;
            write_n_d_r <= 1'b1;
        end else begin
            aleh_d_r    <= aleh_s;
            alel_d_r    <= alel_s;
            read_n_d_r  <= read_n_s;
            write_n_d_r <= write_n_s;
        end
    end

    assign aleh_rise_s  =  aleh_s    & ~aleh_d_r;
    assign aleh_fall_s  = ~aleh_s    &  aleh_d_r;
    assign alel_fall_s  = ~alel_s    &  alel_d_r;
    assign read_fall_s  = ~read_n_s  &  read_n_d_r;
    assign read_rise_s  =  read_n_s  & ~read_n_d_r;
    assign write_rise_s =  write_n_s & ~write_n_d_r;
    assign read_edge_s  =  read_fall_s | read_rise_s;

    // ------------------------------------------------------------------
    // Main FSM and request/address datapath
    // ------------------------------------------------------------------
    state_t      state_r;
    state_t      state_next_s;
    logic [31:0] address_r;
    logic [31:0] address_next_s;
    logic [31:0] base_address_s;
    logic        valid_r;
    logic        read_req_r;
    logic        read_req_next_s;
    logic        write_req_r;
    logic        write_req_next_s;
    logic [15:0] write_data_r;
    logic [15:0] write_data_next_s;
    logic        overrun_r;
    logic        overrun_next_s;
    logic        wr_inc_r;
    logic        wr_inc_next_s;
    logic        pending_s;

    assign pending_s = read_req_r | write_req_r;

    // Next-state, address, request and overrun computation.
    always_comb begin
        state_next_s      = state_r;
        address_next_s    = address_r;
        base_address_s    = address_r;
        read_req_next_s   = read_req_r;
        write_req_next_s  = write_req_r;
        write_data_next_s = write_data_r;
        overrun_next_s    = overrun_r;
        wr_inc_next_s     = 1'b0;

        // An acknowledge retires whichever request is pending. New requests
        // below are only raised when nothing was pending, so they never
        // collide with this clear.
        if (i_ack) begin
            read_req_next_s  = 1'b0;
            write_req_next_s = 1'b0;
        end else begin
            read_req_next_s  = read_req_r;
            write_req_next_s = write_req_r;
        end

        // A write advances the address one cycle after its request rises,
        // so the downstream sees the write's own address for that cycle.
        if (wr_inc_r) begin
            base_address_s = next_address(address_r);
        end else begin
            base_address_s = address_r;
        end
        address_next_s = base_address_s;

        case (state_r)
            ST_IDLE: begin
                if (aleh_s && alel_s) begin
                    state_next_s = ST_ADDR_H;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end

            ST_ADDR_H: begin
                if (aleh_fall_s) begin
                    address_next_s = {ad_s, base_address_s[15:0]};
                    state_next_s   = ST_ADDR_L;
                end else begin
                    state_next_s   = ST_ADDR_H;
                end
            end

            ST_ADDR_L: begin
                if (alel_fall_s && !aleh_rise_s) begin
                    address_next_s = {base_address_s[31:16], ad_s & 16'hFFFE};
                    state_next_s   = ST_DATA;
`ifdef N64_PI_READ_PREFETCH_EN
                    // Fetch the first word as soon as the address is known.
                    if (pending_s) begin
                        overrun_next_s = 1'b1;
                    end else begin
                        read_req_next_s = 1'b1;
                    end
`endif
                end else begin
                    state_next_s = ST_ADDR_L;
                end
            end

            ST_DATA: begin
                if (!aleh_rise_s) begin
                    // Simultaneous /READ and /WRITE edges: the read wins.
                    if (read_edge_s && write_rise_s) begin
                        overrun_next_s = 1'b1;
                    end else begin
                        overrun_next_s = overrun_next_s;
                    end

`ifdef N64_PI_READ_PREFETCH_EN
                    // Advance, then prefetch the word at the new address.
                    if (read_rise_s) begin
                        address_next_s = next_address(base_address_s);
                        if (pending_s) begin
                            overrun_next_s = 1'b1;
                        end else begin
                            read_req_next_s = 1'b1;
                        end
                    end else begin
                        address_next_s = address_next_s;
                    end
`else
                    if (read_fall_s) begin
                        if (pending_s) begin
                            overrun_next_s = 1'b1;
                        end else begin
                            read_req_next_s = 1'b1;
                        end
                    end else begin
                        read_req_next_s = read_req_next_s;
                    end

                    if (read_rise_s) begin
                        address_next_s = next_address(base_address_s);
                    end else begin
                        address_next_s = address_next_s;
                    end
`endif

                    // A dropped write still schedules its address increment.
                    if (write_rise_s && !read_edge_s) begin
                        wr_inc_next_s = 1'b1;
                        if (pending_s) begin
                            overrun_next_s = 1'b1;
                        end else begin
                            write_req_next_s  = 1'b1;
                            write_data_next_s = ad_s;
                        end
                    end else begin
                        wr_inc_next_s = 1'b0;
                    end
                end else begin
                    state_next_s = ST_ADDR_H;
                end
            end

            default: begin
                state_next_s = ST_IDLE;
            end
        endcase

        // A new ALE_H from any state restarts address capture. Pending
        // requests survive the abort; the overrun flag does not.
        if (aleh_rise_s) begin
            state_next_s   = ST_ADDR_H;
            overrun_next_s = 1'b0;
        end else begin
            state_next_s   = state_next_s;
        end
    end

    // State, address, request and flag registers.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_r      <= ST_IDLE;
            address_r    <= 32'h0000_0000;
            valid_r      <= 1'b0;
            read_req_r   <= 1'b0;
            write_req_r  <= 1'b0;
            write_data_r <= 16'h0000;
            overrun_r    <= 1'b0;
            wr_inc_r     <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            address_r    <= address_next_s;
            valid_r      <= (state_next_s == ST_DATA);
            read_req_r   <= read_req_next_s;
            write_req_r  <= write_req_next_s;
            write_data_r <= write_data_next_s;
            overrun_r    <= overrun_next_s;
            wr_inc_r     <= wr_inc_next_s;
        end
    end

    assign o_address       = address_r;
    assign o_address_valid = valid_r;
    assign o_read_request  = read_req_r;
    assign o_write_request = write_req_r;
    assign o_write_data    = write_data_r;
    assign o_overrun       = overrun_r;

endmodule

// File: tb/tb_n64_pi_address_latch.sv
// Self-checking bench for n64_pi_address_latch (default SYNC_STAGES=2,
// ADDRESS_STEP=2). The address model is plain arithmetic on the PI rules:
// start = {hi, lo & FFFE}, every completed transfer adds 2 modulo 2^32.
module tb_n64_pi_address_latch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        aleh;
    logic        alel;
    logic        read_n;
    logic        write_n;
    logic [15:0] ad;
    logic        ack;
    logic [31:0] address;
    logic        valid;
    logic        rreq;
    logic        wreq;
    logic [15:0] wdata;
    logic        overrun;

    int          total_cnt = 0;
    int          pass_cnt  = 0;
    logic [31:0] addr_m;

    typedef struct {
        logic [15:0] hi;
        logic [15:0] lo;
        logic [31:0] exp_start;
        int          nreads;
        logic [31:0] exp_end;
    } vec_t;

    vec_t vecs [5];

    always #5 clk = ~clk;

    n64_pi_address_latch dut (
        .i_clk           (clk),
        .i_reset_n       (rst_n),
        .i_n64_aleh      (aleh),
        .i_n64_alel      (alel),
        .i_n64_read_n    (read_n),
        .i_n64_write_n   (write_n),
        .i_n64_ad        (ad),
        .o_address       (address),
        .o_address_valid (valid),
        .o_read_request  (rreq),
        .o_write_request (wreq),
        .o_write_data    (wdata),
        .i_ack           (ack),
        .o_overrun       (overrun)
    );

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %b expected %b", name, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Bounded poll: 0 = valid, 1 = read request, 2 = write request.
    task automatic wait_for(input int which, input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            tick(1);
            case (which)
                0:       seen = valid;
                1:       seen = rreq;
                2:       seen = wreq;
                default: seen = 1'b0;
            endcase
        end
    endtask

    task automatic ack_pulse();
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
    endtask

    task automatic ale_seq(input logic [15:0] hi, input logic [15:0] lo);
        bit seen;
        alel = 1'b1; aleh = 1'b1; ad = hi;
        tick(4);
        aleh = 1'b0;
        tick(4);
        ad = lo;
        tick(2);
        alel = 1'b0;
        wait_for(0, 4, seen);
        check1("valid_latency", seen, 1'b1);
        addr_m = {hi, lo & 16'hFFFE};
        check32("ale_addr", address, addr_m);
    endtask

    task automatic read_op();
        bit seen;
        read_n = 1'b0;
        wait_for(1, 8, seen);
        check1("rd_req_rise", seen, 1'b1);
        check32("rd_req_addr", address, addr_m);
        tick(2);
        ack_pulse();
        check1("rd_ack_clear", rreq, 1'b0);
        read_n = 1'b1;
        tick(5);
        addr_m = addr_m + 32'd2;
        check32("rd_addr_inc", address, addr_m);
    endtask

    task automatic write_op(input logic [15:0] data);
        bit seen;
        ad = data; write_n = 1'b0;
        tick(4);
        write_n = 1'b1;
        wait_for(2, 8, seen);
        check1("wr_req_rise", seen, 1'b1);
        check32("wr_req_addr", address, addr_m);
        check32("wr_data", {16'h0000, wdata}, {16'h0000, data});
        tick(1);
        addr_m = addr_m + 32'd2;
        check32("wr_addr_inc", address, addr_m);
        ack_pulse();
        check1("wr_ack_clear", wreq, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        check32({tag, "_address"}, address, 32'h0000_0000);
        check1({tag, "_valid"}, valid, 1'b0);
        check1({tag, "_rreq"}, rreq, 1'b0);
        check1({tag, "_wreq"}, wreq, 1'b0);
        check32({tag, "_wdata"}, {16'h0000, wdata}, 32'h0000_0000);
        check1({tag, "_overrun"}, overrun, 1'b0);
    endtask

    initial begin
        bit          seen;
        logic [15:0] hi;
        logic [15:0] lo;
        int          nops;

        vecs[0] = '{16'h1000, 16'h0041, 32'h1000_0040, 4, 32'h1000_0048};
        vecs[1] = '{16'h8000, 16'h0003, 32'h8000_0002, 2, 32'h8000_0006};
        vecs[2] = '{16'hFFFF, 16'hFFFE, 32'hFFFF_FFFE, 1, 32'h0000_0000};
        vecs[3] = '{16'h0000, 16'h0000, 32'h0000_0000, 3, 32'h0000_0006};
        vecs[4] = '{16'hABCD, 16'hFFFD, 32'hABCD_FFFC, 2, 32'hABCE_0000};

        rst_n = 1'b0; aleh = 1'b0; alel = 1'b0; read_n = 1'b1; write_n = 1'b1;
        ad = 16'h0000; ack = 1'b0; addr_m = 32'h0000_0000;
        tick(3);
        check_all_zero("reset");
        rst_n = 1'b1;
        tick(2);

`ifdef N64_PI_READ_PREFETCH_EN
        // Prefetch: request on DATA entry without any /READ.
        ale_seq(16'h1000, 16'h0041);
        check1("pf_entry_req", rreq, 1'b1);
        ack_pulse();
        check1("pf_ack_clear", rreq, 1'b0);
        read_n = 1'b0;
        tick(5);
        check1("pf_fall_no_req", rreq, 1'b0);
        read_n = 1'b1;
        wait_for(1, 8, seen);
        check1("pf_next_req", seen, 1'b1);
        addr_m = addr_m + 32'd2;
        check32("pf_next_addr", address, addr_m);
        ack_pulse();
        check1("pf_ack_clear2", rreq, 1'b0);
`else
        // Table-driven ALE + read bursts.
        for (int i = 0; i < 5; i++) begin
            ale_seq(vecs[i].hi, vecs[i].lo);
            check32("tbl_start", address, vecs[i].exp_start);
            for (int j = 0; j < vecs[i].nreads; j++) read_op();
            check32("tbl_end", address, vecs[i].exp_end);
        end

        // Write at 1E00_4000.
        ale_seq(16'h1E00, 16'h4000);
        write_op(16'hBEEF);
        check32("beef_end_addr", address, 32'h1E00_4002);

        // Second /READ while the first is un-acked.
        ale_seq(16'h2000, 16'h0000);
        read_n = 1'b0;
        wait_for(1, 8, seen);
        check1("ovr_first_req", seen, 1'b1);
        read_n = 1'b1;
        tick(5);
        addr_m = addr_m + 32'd2;
        read_n = 1'b0;
        tick(5);
        check1("ovr_flag", overrun, 1'b1);
        check1("ovr_still_first", rreq, 1'b1);
        ack_pulse();
        tick(3);
        check1("ovr_no_second_req", rreq, 1'b0);
        read_n = 1'b1;
        tick(5);
        addr_m = addr_m + 32'd2;
        check32("ovr_addr", address, addr_m);

        // A new ALE_H clears overrun; strobes outside DATA are ignored.
        aleh = 1'b1; alel = 1'b1;
        tick(5);
        check1("abort_clears_ovr", overrun, 1'b0);
        check1("abort_drops_valid", valid, 1'b0);
        read_n = 1'b0;
        tick(4);
        read_n = 1'b1;
        tick(4);
        check1("outside_no_req", rreq, 1'b0);
        check32("outside_no_inc", address, addr_m);

        // Simultaneous /READ fall and /WRITE rise: only the read is serviced.
        ale_seq(16'h3000, 16'h0010);
        write_n = 1'b0;
        tick(4);
        read_n = 1'b0; write_n = 1'b1;
        tick(5);
        check1("sim_overrun", overrun, 1'b1);
        check1("sim_rreq", rreq, 1'b1);
        check1("sim_no_wreq", wreq, 1'b0);
        check32("sim_addr_held", address, addr_m);
        ack_pulse();
        read_n = 1'b1;
        tick(5);
        addr_m = addr_m + 32'd2;
        check32("sim_addr_inc", address, addr_m);

        // Randomized bursts against the address model.
        for (int r = 0; r < 6; r++) begin
            hi = 16'($urandom);
            lo = 16'($urandom);
            ale_seq(hi, lo);
            nops = $urandom_range(1, 4);
            for (int j = 0; j < nops; j++) begin
                if ($urandom_range(0, 1) == 1) read_op();
                else write_op(16'($urandom));
            end
            check32("rand_end_addr", address, addr_m);
            check1("rand_no_overrun", overrun, 1'b0);
        end
`endif

        // Reset mid-burst with a request pending.
        ale_seq(16'h4000, 16'h0100);
`ifndef N64_PI_READ_PREFETCH_EN
        read_n = 1'b0;
`endif
        wait_for(1, 8, seen);
        check1("rst_req_pending", seen, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        read_n = 1'b1; aleh = 1'b0; alel = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(2);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
